// File: rtl/life_grid_engine.sv
// Game of Life grid engine: cell array, generation tick, run/pause/step,
// cursor editing, and population / stability tracking.
module life_grid_engine #(
  parameter int         WIDTH        = 16,
  parameter int         HEIGHT       = 16,
  parameter int         WRAP         = 0,
  parameter int         TICK_DIV     = 1024,
  parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pause,
  input  logic                        step,
  input  logic                        clear,
  input  logic                        key_up,
  input  logic                        key_down,
  input  logic                        key_left,
  input  logic                        key_right,
  input  logic                        toggle,
  output logic [HEIGHT*WIDTH-1:0]     cells,
  output logic [$clog2(WIDTH)-1:0]    cursor_x,
  output logic [$clog2(HEIGHT)-1:0]   cursor_y,
  output logic [15:0]                 generation,
  output logic [8:0]                  population,
  output logic                        stable
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int IW = $clog2(N);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);

  logic [N-1:0]    r_cells;
  logic [XW-1:0]   r_cx;
  logic [YW-1:0]   r_cy;
  logic [15:0]     r_gen;
  logic [8:0]      r_pop;
  logic            r_stable;
  logic [TW-1:0]   r_tick;

  logic [N-1:0]    w_next;
  logic [8:0]      w_next_pop;
  logic [3:0]      w_cnt;
  int              w_nx;
  int              w_ny;
  logic            w_tick_wrap;
  logic            w_update;
  logic [XW-1:0]   w_cx;
  logic [YW-1:0]   w_cy;
  logic [IW-1:0]   w_tidx;

  assign w_tick_wrap = (r_tick == TICK_LAST);
  assign w_update    = pause ? step : w_tick_wrap;
  assign w_tidx      = IW'(int'(r_cy) * WIDTH + int'(r_cx));

  // Whole next generation from the registered grid in one pass.
  always_comb begin
    w_next = '0;
    w_cnt  = '0;
    w_nx   = 0;
    w_ny   = 0;
    for (int y = 0; y < HEIGHT; y++) begin
      for (int x = 0; x < WIDTH; x++) begin
        w_cnt = '0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            w_nx = x + dx;
            w_ny = y + dy;
            if (WRAP != 0) begin
              if (w_nx < 0) w_nx = WIDTH - 1;
              else if (w_nx >= WIDTH) w_nx = 0;
              if (w_ny < 0) w_ny = HEIGHT - 1;
              else if (w_ny >= HEIGHT) w_ny = 0;
            end
            if (!(dx == 0 && dy == 0) &&
                w_nx >= 0 && w_nx < WIDTH &&
                w_ny >= 0 && w_ny < HEIGHT)
              w_cnt = w_cnt +
                4'(r_cells[IW'(w_ny * WIDTH + w_nx)]);
          end
        end
        w_next[IW'(y * WIDTH + x)] =
          r_cells[IW'(y * WIDTH + x)] ?
          SURVIVE_MASK[w_cnt] : BIRTH_MASK[w_cnt];
      end
    end
  end

  always_comb begin
    w_next_pop = '0;
    for (int i = 0; i < N; i++)
      w_next_pop = w_next_pop + 9'(w_next[i]);
  end

  // Opposing keys on one axis cancel.
  always_comb begin
    w_cx = r_cx;
    if (key_left && !key_right) begin
      if (r_cx == '0) w_cx = (WRAP != 0) ? X_LAST : '0;
      else w_cx = r_cx - 1'b1;
    end else if (key_right && !key_left) begin
      if (r_cx == X_LAST) w_cx = (WRAP != 0) ? '0 : X_LAST;
      else w_cx = r_cx + 1'b1;
    end
  end

  always_comb begin
    w_cy = r_cy;
    if (key_up && !key_down) begin
      if (r_cy == '0) w_cy = (WRAP != 0) ? Y_LAST : '0;
      else w_cy = r_cy - 1'b1;
    end else if (key_down && !key_up) begin
      if (r_cy == Y_LAST) w_cy = (WRAP != 0) ? '0 : Y_LAST;
      else w_cy = r_cy + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cells  <= '0;
      r_cx     <= XW'(WIDTH / 2);
      r_cy     <= YW'(HEIGHT / 2);
      r_gen    <= '0;
      r_pop    <= '0;
      r_stable <= 1'b0;
      r_tick   <= '0;
    end else begin
      r_cx <= w_cx;
      r_cy <= w_cy;
      if (clear) begin
        r_cells  <= '0;
        r_gen    <= '0;
        r_pop    <= '0;
        r_stable <= 1'b0;
        r_tick   <= '0;
      end else begin
        if (!pause)
          r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
        if (w_update) begin
          r_cells  <= w_next;
          r_pop    <= w_next_pop;
          r_stable <= (w_next == r_cells);
          r_gen    <= r_gen + 16'd1;
        end else if (pause && toggle) begin
          r_cells[w_tidx] <= ~r_cells[w_tidx];
          r_pop    <= r_cells[w_tidx] ? r_pop - 9'd1
                                      : r_pop + 9'd1;
          r_stable <= 1'b0;
        end
      end
    end
  end

  assign cells      = r_cells;
  assign cursor_x   = r_cx;
  assign cursor_y   = r_cy;
  assign generation = r_gen;
  assign population = r_pop;
  assign stable     = r_stable;

endmodule

// File: doc/life_grid_engine.md
Name: life_grid_engine

Overview:
- Parametrised Game of Life engine. Holds a WIDTH x HEIGHT cell array, a timed generation tick, run/pause/single-step control, and a cursor for editing cells.
- Replaces the per-cell instance mesh in the board top. Drives the pixel array consumed by the LED driver and takes debounced one-cycle key pulses from player_input.
- Adds selectable edge mode, configurable rule masks, a generation counter, population count and a stable-pattern flag.

Parameters:
WIDTH, 16, grid columns (2..16)
HEIGHT, 16, grid rows (2..16)
WRAP, 0, 0 = cells beyond the edge read as dead; 1 = toroidal neighbours and cursor wrap
TICK_DIV, 1024, clk cycles per generation while running (>=1)
BIRTH_MASK, 9'b000001000, bit n set -> a dead cell with n live neighbours becomes alive
SURVIVE_MASK, 9'b000001100, bit n set -> a live cell with n live neighbours stays alive

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pause  in  1  level; 1 = generation ticks halted, editing enabled
step  in  1  one-cycle pulse; while paused, forces one generation update
clear  in  1  one-cycle pulse; kills all cells
key_up, key_down, key_left, key_right  in  1 each  one-cycle cursor move pulses
toggle  in  1  one-cycle pulse; inverts the cell under the cursor (paused only)
cells  out  HEIGHT*WIDTH  cell state, bit [y*WIDTH+x]
cursor_x  out  $clog2(WIDTH)  cursor column
cursor_y  out  $clog2(HEIGHT)  cursor row
generation  out  16  generations computed since reset or clear
population  out  9  live cells in cells
stable  out  1  last generation update produced no change

Behaviour:
- Reset (reset=0, asynchronous):
  - cells=0, generation=0, population=0, stable=0.
  - Tick counter = 0.
  - cursor_x=WIDTH/2, cursor_y=HEIGHT/2.
- Tick counter:
  - Increments each cycle while pause=0.
  - At TICK_DIV-1 it wraps to 0 and asserts an internal update for that cycle.
  - While pause=1 it holds its value and does not clear.
- Update source: tick (pause=0), or step (pause=1). step while pause=0 is ignored.
- Generation update, single cycle, all cells at once from the current registered grid:
  - Neighbour count n in 0..8, using the 8 surrounding cells.
  - Out-of-range neighbours: dead when WRAP=0, modulo index when WRAP=1.
  - next = cell ? SURVIVE_MASK[n] : BIRTH_MASK[n].
  - On the same edge: population <= popcount(next); stable <= (next == cells).
  - generation increments and wraps 16'hFFFF -> 0.
  - Latency: cells change on the clk edge where the update is asserted.
- Cursor:
  - Moves on key pulses in both run and pause states.
  - key_up decrements y; key_down increments y; key_left decrements x; key_right increments x.
  - At an edge: clamp when WRAP=0, wrap to the opposite side when WRAP=1.
  - Opposing pulses in the same cycle (up+down, left+right) cancel on that axis.
  - Orthogonal pulses in the same cycle both apply.
- Toggle:
  - While pause=1, inverts cells[cursor] using the cursor value before any move in the same cycle.
  - population is adjusted by +-1 on the same edge.
  - stable is cleared to 0.
  - Ignored while pause=0.
- Clear:
  - cells=0, population=0, generation=0, stable=0.
  - Tick counter reset to 0. Cursor is unchanged.
- Priority within one cycle: clear > generation update > toggle. A toggle coinciding with an update is dropped.
- A deasserting reset mid-run restarts from the reset state; no partial generation is ever visible.

Test Plan:
1. Blinker, WRAP=0, TICK_DIV=4, paused; toggle cells (7,8),(8,8),(9,8); pause=0 -> vertical (8,7),(8,8),(8,9) after 4 cycles, horizontal after 8; population=3, stable=0 throughout, generation=2.
2. Glider, WRAP=1, 16x16, pause=1; place glider at the top-left; 64 step pulses -> cells identical to the start pattern, generation=64, population=5.
3. Edge mode, 2x2 block at (0,0)..(1,1); WRAP=0 -> unchanged after 1 step, stable=1. WRAP=1 on a 4x4 grid with a single live cell -> dead after 1 step, population=0.
4. Cursor from reset (8,8): 9 key_left -> x=0 (WRAP=0) or x=15 (WRAP=1); key_up+key_down in the same cycle -> y unchanged.
5. Pause gating: pause=0 with toggle -> no cell change. pause=1 with step and toggle in the same cycle -> generation result only, toggle dropped.
6. Clear and toggle in the same cycle -> cells=0, generation=0. Assert reset mid-tick -> all outputs at reset values immediately, without waiting for clk.
